serial_fourbit_adder: RTL and testbench

Bit-serial adder: the addition counterpart of the lab's combinational 4-bit subtractor. It takes two WIDTH-bit operands on a start pulse and adds them one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. It presents a registered sum and carry-out with a one-cycle done pulse. Stimulus and checking reuse the subtractor bench style, with X, Y and the $monitor-based checking.

---
 rtl/serial_fourbit_adder.sv | 185 ++++++++++++++++++
 tb/tb_serial_fourbit_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_fourbit_adder.sv
// -----------------------------------------------------------------------------
// serial_fourbit_adder
//
// Bit-serial adder. On an accepted start the two WIDTH-bit operands are
// captured, then added one bit per clock (LSB first) through a single
// full-adder slice and a carry flip-flop. When the last bit has been formed
// the complete sum and the final carry are copied to the output registers and
// done pulses for one cycle.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      operation request, only looked at in IDLE
//   X      in   WIDTH  augend, captured on the accepting edge
//   Y      in   WIDTH  addend, captured on the accepting edge
//   busy   out  1      operation in progress (SHIFT)
//   done   out  1      one-cycle pulse, sum/carry just updated
//   sum    out  WIDTH  (X+Y) mod 2^WIDTH, registered, held between results
//   carry  out  1      carry-out of bit WIDTH-1, registered, held
//
// Parameters
//   WIDTH  operand width, 2..16
// -----------------------------------------------------------------------------
module serial_fourbit_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Counter only has to reach WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Full-adder carry: majority of the three inputs.
    function automatic logic fa_maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_e             state_q;
    logic [WIDTH-1:0]   reg_a_q;
    logic [WIDTH-1:0]   reg_b_q;
    logic [WIDTH-1:0]   sum_sh_q;
    logic               c_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;

    logic               fa_sum_d;
    logic               fa_carry_d;
    logic [WIDTH-1:0]   sum_sh_d;

    // Bit slice: current LSBs plus carry FF, and the sum register after this bit.
    always_comb begin
        fa_sum_d   = 1'b0;
        fa_carry_d = 1'b0;
        sum_sh_d   = '0;
        fa_sum_d   = fa_sum(reg_a_q[0], reg_b_q[0], c_q);
        fa_carry_d = fa_maj(reg_a_q[0], reg_b_q[0], c_q);
        // New bit enters at the MSB so after WIDTH shifts bit 0 sits at bit 0.
        sum_sh_d   = {fa_sum_d, sum_sh_q[WIDTH-1:1]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        reg_a_q  <= X;
                        reg_b_q  <= Y;
                        sum_sh_q <= '0;
                        c_q      <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    reg_a_q  <= reg_a_q >> 1;
                    reg_b_q  <= reg_b_q >> 1;
                    sum_sh_q <= sum_sh_d;
                    c_q      <= fa_carry_d;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        // Last bit: publish the result straight from the
                        // next-state values so no partial sum is ever visible.
                        sum_q   <= sum_sh_d;
                        carry_q <= fa_carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: recover quietly to IDLE.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

    serial_fourbit_adder_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .busy (busy_q),
        .done (done_q)
    );

endmodule

// -----------------------------------------------------------------------------
// serial_fourbit_adder_chk
//
// Protocol properties of the adder's handshake outputs.
//
// Ports
//   clk, rst  clock and asynchronous reset of the adder
//   busy      adder busy output
//   done      adder done output
// -----------------------------------------------------------------------------
module serial_fourbit_adder_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic done
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));

    a_done_one_cycle: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_serial_fourbit_adder.sv
// Testbench for serial_fourbit_adder (WIDTH=4). Expected results come from
// plain integer addition of the captured operands; latency and throughput
// expectations come from the documented edge timing.
module tb_serial_fourbit_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int tests_run;
    int tests_failed;

    // Last published result; outputs must hold it while an operation runs.
    logic [W:0] held_result;

    serial_fourbit_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation: start pulse with x/y, optional operand change right
    // after the accepting edge, then result, latency and hold checks.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit chg, input logic [W-1:0] nx, input logic [W-1:0] ny,
                         input bit hold_checks);
        logic [W:0] expv;
        int         k;
        bit         seen;
        expv = {1'b0, x} + {1'b0, y};
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        @(posedge clk);               // accepting edge E0
        @(negedge clk);
        start = 1'b0;
        if (chg) begin
            X = nx; Y = ny;
        end
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else if (hold_checks) begin
                chk("busy_during_shift", {31'd0, busy}, 32'd1);
                chk("result_held", {27'd0, carry, sum}, {27'd0, held_result});
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency_edges", k, W);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("result", {27'd0, carry, sum}, {27'd0, expv});
        held_result = expv;
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [W:0] q_exp[$];
        logic [W:0] e;
        int         ndone;
        int         nbusy_rise;
        logic       busy_prev;

        tests_run    = 0;
        tests_failed = 0;
        held_result  = '0;
        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        Y     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {27'd0, carry, sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Directed sums and overflow cases
        do_op(4'd2,  4'd1,  1'b0, 4'd0, 4'd0, 1'b1);
        do_op(4'd6,  4'd4,  1'b0, 4'd0, 4'd0, 1'b1);
        do_op(4'd15, 4'd7,  1'b0, 4'd0, 4'd0, 1'b1);
        do_op(4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 1'b1);
        do_op(4'd0,  4'd0,  1'b0, 4'd0, 4'd0, 1'b1);

        // Operands changed after capture must not matter
        do_op(4'd5, 4'd10, 1'b1, 4'd0, 4'd8, 1'b1);

        // Start pulsed again in the 2nd SHIFT cycle: exactly one done
        @(negedge clk);
        X = 4'd3; Y = 4'd9; start = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);               // E1
        @(negedge clk);
        start = 1'b1;                 // sampled at E2, in SHIFT
        X = 4'd1; Y = 4'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        nbusy_rise = 0;
        busy_prev = busy;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("restart_ignored_result", {27'd0, carry, sum}, 32'd12);
            end
            if (busy && !busy_prev) nbusy_rise++;
            busy_prev = busy;
        end
        chk("restart_done_count", ndone, 1);
        chk("restart_busy_rise", nbusy_rise, 0);
        held_result = 5'd12;

        // start held high for 20 cycles: accepts every W+2 edges
        ndone = 0;
        for (int i = 0; i < 26; i++) begin
            X = W'($urandom);
            Y = W'($urandom);
            start = (i < 20) ? 1'b1 : 1'b0;
            if (i < 20 && (i % (W + 2)) == 0) q_exp.push_back({1'b0, X} + {1'b0, Y});
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("b2b_pulse_phase", i % (W + 2), W);
                e = (q_exp.size() > 0) ? q_exp.pop_front() : '0;
                chk("b2b_result", {27'd0, carry, sum}, {27'd0, e});
                held_result = e;
            end
        end
        chk("b2b_done_count", ndone, 4);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        X = 4'd9; Y = 4'd9; start = 1'b1;
        @(posedge clk);               // E0
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);               // E1
        @(posedge clk);               // E2
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {27'd0, carry, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        held_result = '0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        do_op(4'd3, 4'd4, 1'b0, 4'd0, 4'd0, 1'b1);

        // Exhaustive sweep against integer addition
        $monitor("[MON] t=%0t X=%0d Y=%0d sum=%0d carry=%0b", $time, X, Y, sum, carry);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(W'(a), W'(b), 1'b0, 4'd0, 4'd0, 1'b0);
            end
        end
        $monitoroff;

        // Random operations with random post-capture operand changes
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'b1, W'($urandom), W'($urandom), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
